hazard_detection_unit: RTL

Stall-and-flush controller for the five-stage MIPS pipeline. It handles the hazards that bypassing cannot resolve:
- load-use dependences;
- reads of HI/LO while the multi-cycle multiply/divide unit is still running;
- taken branches and jumps resolved in EX.

It sits beside the forwarding logic in the ID stage. It drives the PC and IF/ID write enables, the ID/EX bubble mux and the IF/ID flush, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_detection_unit_pkg.sv | 16 +
 rtl/hazard_detection_unit_muldiv_busy_counter.sv | 62 ++++++
 rtl/hazard_detection_unit.sv | 74 +++++++
 3 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the ID-stage hazard detection unit.
package hazard_detection_unit_pkg;

    // Multiply/divide tracker state: idle pipeline or unit still occupied.
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    // EX-stage occupancy of mult/multu/div/divu unless overridden.
    localparam int MULDIV_CYCLES_DEFAULT = 4;

    // Width of the saturating stall-cycle counter.
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/hazard_detection_unit_muldiv_busy_counter.sv
// Tracks how long the multi-cycle multiply/divide unit remains occupied
// after a mult/div leaves EX, and reports busy while it does.
module muldiv_busy_counter
    import hazard_detection_unit_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    // Remaining cycles after the issuing cycle; 4 bits covers up to 16.
    localparam logic [3:0] RELOAD = 4'(MULDIV_CYCLES - 1);

    mdState_t   state, stateNext;
    logic [3:0] mdCnt, mdCntNext;

    // State and countdown registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            mdCnt <= 4'd0;
        end else begin
            state <= stateNext;
            mdCnt <= mdCntNext;
        end
    end

    // Next-state: start (re)loads the countdown; leaving BUSY on the 1->0 step.
    always_comb begin
        stateNext = state;
        mdCntNext = mdCnt;
        case (state)
            RUN: begin
                if (start) begin
                    stateNext = MD_BUSY;
                    mdCntNext = RELOAD;
                end
            end
            MD_BUSY: begin
                if (start) begin
                    mdCntNext = RELOAD;
                end else if (mdCnt <= 4'd1) begin
                    // <= also recovers from a zero count should one ever appear
                    stateNext = RUN;
                    mdCntNext = 4'd0;
                end else begin
                    mdCntNext = mdCnt - 4'd1;
                end
            end
            default: begin
                stateNext = RUN;
                mdCntNext = 4'd0;
            end
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage stall/flush controller: load-use and HI/LO interlocks, EX-resolved
// branch flush, and a saturating stall-cycle performance counter.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_ID_EX_MemRead,
    input  logic [4:0]             in_ID_EX_Rt_address_5,
    input  logic [4:0]             in_IF_ID_Rs_address_5,
    input  logic [4:0]             in_IF_ID_Rt_address_5,
    input  logic                   in_IF_ID_uses_rs,
    input  logic                   in_IF_ID_uses_rt,
    input  logic                   in_IF_ID_reads_hilo,
    input  logic                   in_ID_EX_muldiv_start,
    input  logic                   in_EX_branch_taken,
    output logic                   o_PC_write,
    output logic                   o_IF_ID_write,
    output logic                   o_ID_EX_bubble,
    output logic                   o_IF_ID_flush,
    output logic                   o_muldiv_busy,
    output logic [STALL_CNT_W-1:0] o_stall_count_16
);

    logic rsHit, rtHit, loadUse, hiloHazard, stall;

    muldiv_busy_counter #(
        .MULDIV_CYCLES(MULDIV_CYCLES)
    ) uMdCounter (
        .clk  (clk),
        .reset(reset),
        .start(in_ID_EX_muldiv_start),
        .busy (o_muldiv_busy)
    );

    // Hazard terms; $0 as a load destination never creates a dependence.
    always_comb begin
        rsHit      = in_IF_ID_uses_rs && (in_IF_ID_Rs_address_5 == in_ID_EX_Rt_address_5);
        rtHit      = in_IF_ID_uses_rt && (in_IF_ID_Rt_address_5 == in_ID_EX_Rt_address_5);
        loadUse    = in_ID_EX_MemRead && (in_ID_EX_Rt_address_5 != 5'd0) && (rsHit || rtHit);
        // A mult/div in EX this cycle is busy before the tracker has registered it.
        hiloHazard = in_IF_ID_reads_hilo && (in_ID_EX_muldiv_start || o_muldiv_busy);
        // A taken branch squashes the ID instruction, so its hazard is moot.
        stall      = (loadUse || hiloHazard) && !in_EX_branch_taken;
    end

    // Priority mux: flush wins over stall; otherwise the pipeline advances.
    always_comb begin
        o_PC_write     = 1'b1;
        o_IF_ID_write  = 1'b1;
        o_ID_EX_bubble = 1'b0;
        o_IF_ID_flush  = 1'b0;
        if (in_EX_branch_taken) begin
            o_ID_EX_bubble = 1'b1;
            o_IF_ID_flush  = 1'b1;
        end else if (stall) begin
            o_PC_write     = 1'b0;
            o_IF_ID_write  = 1'b0;
            o_ID_EX_bubble = 1'b1;
        end
    end

    // Stall-cycle counter, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_stall_count_16 <= '0;
        end else if (stall && (o_stall_count_16 != {STALL_CNT_W{1'b1}})) begin
            o_stall_count_16 <= o_stall_count_16 + 1'b1;
        end
    end

endmodule
